mem_stage_bus_ctrl: RTL and testbench
=====================================

// Module: mem_stage_bus_ctrl
// PURPOSE
// MEM-stage data-bus controller. Sits between EXMEM and MEMWB.
// Turns a load/store from EX into a req/addr_ok/data_ok transaction on the data RAM bus.
// Generates byte lanes and store data, and detects misaligned addresses.
// Holds the pipeline with stall_request until the access completes.
// Passes raw read data and lane select to MEMWB (ram_read_data_in, mem_sel_in).
// PARAMETERS
// ADDR_WIDTH  32  byte address width
// DATA_WIDTH  32  data width; fixed at 32 (4 byte lanes)
// PORTS
// clk                  in   1   clock; all state updates on posedge
// rst                  in   1   synchronous, active-low reset
// stall_current_stage  in   1   MEM held by the pipeline controller; access stays DONE
// flush                in   1   kill the current MEM instruction (exception/eret)
// mem_read_flag_in     in   1   load
// mem_write_flag_in    in   1   store
// mem_size_in          in   2   0=byte 1=half 2=word 3=reserved (treated as word)
// address_in           in   32  effective address (ALU result)
// mem_write_data_in    in   32  store source register value
// ram_req              out  1   bus request
// ram_wr               out  1   1=write 0=read
// ram_sel              out  4   byte enables
// ram_addr             out  32  word-aligned address ({addr[31:2],2'b00})
// ram_wdata            out  32  lane-replicated store data
// ram_addr_ok          in   1   request accepted this cycle
// ram_data_ok          in   1   data returned / write done this cycle
// ram_rdata            in   32  read data, valid with ram_data_ok
// mem_sel_out          out  4   lanes to MEMWB (combinational from inputs)
// ram_read_data_out    out  32  captured read data to MEMWB
// stall_request        out  1   stall IF..MEM
// adel_out / ades_out  out  1   load / store address error (combinational)
// BEHAVIOUR
// - Lanes: byte sel=4'b0001<<addr[1:0], wdata={4{d[7:0]}}.
//   half sel=addr[1]?1100:0011, wdata={2{d[15:0]}}. word sel=1111, wdata=d.
// - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//   Load raises adel_out, store raises ades_out. No bus access; stall_request=0.
// - access = (read|write) & !misaligned & !flush.
// - FSM states:
//   IDLE -> REQ when access.
//   REQ: ram_req=1; addr/sel/wr/wdata held stable.
//     On addr_ok -> WAIT.
//     On flush with no addr_ok -> IDLE; req drops next cycle.
//   WAIT: on data_ok capture ram_rdata (reads only) -> DONE.
//     On flush -> DRAIN.
//   DRAIN: wait for data_ok, discard the data -> IDLE.
//   DONE: stall_request=0. On !stall_current_stage -> IDLE.
//     DONE blocks re-issue of the same instruction.
// - ram_req is registered: first asserted the cycle after IDLE sees access.
//   Minimum latency is addr_ok and data_ok in consecutive cycles:
//   IDLE, REQ, WAIT, DONE = 4 cycles.
// - addr_ok and data_ok in the same cycle in REQ -> capture data, go to DONE (skip WAIT).
// - stall_request = (IDLE & access) | REQ | WAIT | DRAIN. Low in DONE.
// - Stores: ram_read_data_out is unchanged.
// - Reset (any state, including mid-transaction): state=IDLE, ram_req=0, ram_wr=0,
//   ram_sel=0, ram_addr=0, ram_wdata=0, ram_read_data_out=0.
// - Flush in DONE or IDLE: state goes to / stays IDLE.
// TESTING
// - lw 0x100, addr_ok +1 cycle, data_ok +2 cycles, rdata=0xDEADBEEF
//   -> sel=1111, out=0xDEADBEEF in DONE, stall high exactly 4 cycles.
// - sb 0x203 data 0x000000A5 -> ram_sel=1000, ram_wdata=0xA5A5A5A5, ram_wr=1, ram_addr=0x200.
// - lh 0x101 -> adel_out=1, ram_req never asserted, stall_request=0.
//   sw 0x102 -> ades_out=1.
// - addr_ok held low 5 cycles -> req/addr/sel stable throughout; flush on cycle 3 -> req low next cycle, IDLE.
// - flush in WAIT, data_ok 2 cycles later with 0x12345678
//   -> ram_read_data_out unchanged, stall until data_ok, then IDLE.
// - rst=0 asserted in WAIT -> next cycle all outputs 0, IDLE.
//   Late data_ok ignored; a new lw issues normally.

Source files
------------

// File: rtl/mem_stage_bus_ctrl_if.sv
// Data RAM bus between the MEM-stage controller (master) and the memory (slave).
// Uses a req/addr_ok/data_ok handshake with word-aligned addresses and byte enables.
interface mem_stage_bus_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  ram_req;
    logic                  ram_wr;
    logic [3:0]            ram_sel;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_addr_ok;
    logic                  ram_data_ok;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (
        output ram_req, ram_wr, ram_sel, ram_addr, ram_wdata,
        input  ram_addr_ok, ram_data_ok, ram_rdata
    );

    modport slave (
        input  ram_req, ram_wr, ram_sel, ram_addr, ram_wdata,
        output ram_addr_ok, ram_data_ok, ram_rdata
    );
endinterface

// File: rtl/mem_stage_bus_ctrl.sv
// MEM-stage data-bus controller: turns EX loads/stores into bus transactions, generates
// byte lanes, flags misaligned addresses and stalls the pipeline until the access completes.
module mem_stage_bus_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_current_stage,
    input  logic                  flush,
    input  logic                  mem_read_flag_in,
    input  logic                  mem_write_flag_in,
    input  logic [1:0]            mem_size_in,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0] mem_write_data_in,
    mem_stage_bus_ctrl_if.master  ram,
    output logic [3:0]            mem_sel_out,
    output logic [DATA_WIDTH-1:0] ram_read_data_out,
    output logic                  stall_request,
    output logic                  adel_out,
    output logic                  ades_out
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            sel;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  misaligned;
    logic                  access;
    logic                  issue;
    logic                  capture;

    logic                  wr_q;
    logic [3:0]            sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Reserved size 3 falls into the word branch.
    always_comb begin
        sel        = 4'b1111;
        wdata      = mem_write_data_in;
        misaligned = 1'b0;
        unique case (mem_size_in)
            2'd0: begin
                sel   = 4'b0001 << address_in[1:0];
                wdata = {4{mem_write_data_in[7:0]}};
            end
            2'd1: begin
                sel        = address_in[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{mem_write_data_in[15:0]}};
                misaligned = address_in[0];
            end
            default: misaligned = |address_in[1:0];
        endcase
    end

    assign access      = (mem_read_flag_in | mem_write_flag_in) & ~misaligned & ~flush;
    assign mem_sel_out = sel;
    assign adel_out    = mem_read_flag_in & misaligned;
    assign ades_out    = mem_write_flag_in & misaligned;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    state_d = StReq;
                    issue   = 1'b1;
                end
            end
            StReq: begin
                if (ram.ram_addr_ok) begin
                    if (ram.ram_data_ok) begin
                        state_d = flush ? StIdle : StDone;
                        capture = ~flush;
                    end else begin
                        state_d = flush ? StDrain : StWait;
                    end
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (ram.ram_data_ok) begin
                    state_d = flush ? StIdle : StDone;
                    capture = ~flush;
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (ram.ram_data_ok) state_d = StIdle;
            end
            StDone: begin
                if (flush || !stall_current_stage) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            sel_q   <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            // Bus attributes are latched once at issue so they stay stable while in REQ.
            if (issue) begin
                wr_q    <= mem_write_flag_in;
                sel_q   <= sel;
                addr_q  <= {address_in[ADDR_WIDTH-1:2], 2'b00};
                wdata_q <= wdata;
            end
            if (capture && !wr_q) rdata_q <= ram.ram_rdata;
        end
    end

    assign ram.ram_req     = (state_q == StReq);
    assign ram.ram_wr      = wr_q;
    assign ram.ram_sel     = sel_q;
    assign ram.ram_addr    = addr_q;
    assign ram.ram_wdata   = wdata_q;
    assign ram_read_data_out = rdata_q;

    assign stall_request = ((state_q == StIdle) && access) || (state_q == StReq) ||
                           (state_q == StWait) || (state_q == StDrain);

endmodule

// File: tb/tb_mem_stage_bus_ctrl.sv
// Scoreboard bench for mem_stage_bus_ctrl: a RAM responder with programmable latencies,
// directed load/store/flush/reset sequences, and a monitor checking bus accepts and results.
module tb_mem_stage_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_current_stage = 1'b0;
    logic        flush = 1'b0;
    logic        mem_read_flag_in = 1'b0;
    logic        mem_write_flag_in = 1'b0;
    logic [1:0]  mem_size_in = 2'd0;
    logic [31:0] address_in = 32'd0;
    logic [31:0] mem_write_data_in = 32'd0;
    logic [3:0]  mem_sel_out;
    logic [31:0] ram_read_data_out;
    logic        stall_request;
    logic        adel_out;
    logic        ades_out;

    always #5 clk = ~clk;

    mem_stage_bus_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_stage_bus_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_current_stage (stall_current_stage),
        .flush               (flush),
        .mem_read_flag_in    (mem_read_flag_in),
        .mem_write_flag_in   (mem_write_flag_in),
        .mem_size_in         (mem_size_in),
        .address_in          (address_in),
        .mem_write_data_in   (mem_write_data_in),
        .ram                 (bus),
        .mem_sel_out         (mem_sel_out),
        .ram_read_data_out   (ram_read_data_out),
        .stall_request       (stall_request),
        .adel_out            (adel_out),
        .ades_out            (ades_out)
    );

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        wr;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_rd_q[$];

    function automatic void check(input string name, input logic [95:0] act,
                                  input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // RAM responder
    int          addr_lat = 1;
    int          data_lat = 1;
    logic [31:0] resp_data = 32'd0;
    int          r_acnt = 0;
    int          r_dcnt = 0;
    bit          r_pend = 1'b0;

    initial begin
        bus.ram_addr_ok = 1'b0;
        bus.ram_data_ok = 1'b0;
        bus.ram_rdata   = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.ram_addr_ok = 1'b0;
            bus.ram_data_ok = 1'b0;
            if (r_pend) begin
                r_dcnt++;
                if (r_dcnt >= data_lat) begin
                    bus.ram_data_ok = 1'b1;
                    bus.ram_rdata   = resp_data;
                    r_pend          = 1'b0;
                end
            end else if (bus.ram_req) begin
                if (r_acnt >= addr_lat) begin
                    bus.ram_addr_ok = 1'b1;
                    r_acnt          = 0;
                    if (data_lat == 0) begin
                        bus.ram_data_ok = 1'b1;
                        bus.ram_rdata   = resp_data;
                    end else begin
                        r_pend = 1'b1;
                        r_dcnt = 0;
                    end
                end else begin
                    r_acnt++;
                end
            end else begin
                r_acnt = 0;
            end
        end
    end

    // Monitor: bus accepts and end-of-stall results
    logic prev_stall = 1'b0;
    req_t mon_e;

    always @(negedge clk) begin
        if (bus.ram_req && bus.ram_addr_ok) begin
            if (exp_req_q.size() == 0) begin
                check("bus_accept_unexpected", 96'(1), 96'(0));
            end else begin
                mon_e = exp_req_q.pop_front();
                check("bus_accept", 96'({bus.ram_wr, bus.ram_sel, bus.ram_addr, bus.ram_wdata}),
                      96'(mon_e));
            end
        end
        if (prev_stall && !stall_request) begin
            if (exp_rd_q.size() == 0) begin
                check("result_unexpected", 96'(1), 96'(0));
            end else begin
                check("read_data_out", 96'(ram_read_data_out), 96'(exp_rd_q.pop_front()));
            end
        end
        prev_stall <= stall_request;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        mem_read_flag_in  = rd;
        mem_write_flag_in = wr;
        mem_size_in       = sz;
        address_in        = a;
        mem_write_data_in = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    // Counts stall cycles from the current cycle until stall_request drops (bounded).
    task automatic wait_done(input string name, input int exp_stalls);
        int n;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (stall_request) n++;
            else break;
        end
        check({name, "_stall_cycles"}, 96'(n), 96'(exp_stalls));
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus", 96'({bus.ram_req, bus.ram_wr, bus.ram_sel, bus.ram_addr}), 96'(0));
        check("rst_wdata", 96'(bus.ram_wdata), 96'(0));
        check("rst_rdata_out", 96'(ram_read_data_out), 96'(0));
        check("rst_stall", 96'(stall_request), 96'(0));
        nxt();
        rst = 1'b1;
        nxt();

        // lw 0x100
        addr_lat = 1; data_lat = 1; resp_data = 32'hDEADBEEF;
        exp_req_q.push_back({1'b0, 4'b1111, 32'h100, 32'h0});
        exp_rd_q.push_back(32'hDEADBEEF);
        drive(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        wait_done("lw", 4);
        check("lw_sel", 96'(mem_sel_out), 96'(4'b1111));
        nxt(); idle(); nxt();

        // sb 0x203
        exp_req_q.push_back({1'b1, 4'b1000, 32'h200, 32'hA5A5A5A5});
        exp_rd_q.push_back(32'hDEADBEEF);
        drive(1'b0, 1'b1, 2'd0, 32'h203, 32'h000000A5);
        wait_done("sb", 4);
        nxt(); idle(); nxt();

        // lb 0x202 with addr_ok and data_ok in the same cycle
        addr_lat = 0; data_lat = 0; resp_data = 32'hCAFEF00D;
        exp_req_q.push_back({1'b0, 4'b0100, 32'h200, 32'h44444444});
        exp_rd_q.push_back(32'hCAFEF00D);
        drive(1'b1, 1'b0, 2'd0, 32'h202, 32'h11223344);
        wait_done("lb_fast", 2);
        check("lb_sel", 96'(mem_sel_out), 96'(4'b0100));
        nxt(); idle(); nxt();

        // lh 0x206, then hold in DONE with stall_current_stage
        addr_lat = 0; data_lat = 1; resp_data = 32'h0BADF00D;
        exp_req_q.push_back({1'b0, 4'b1100, 32'h204, 32'h33443344});
        exp_rd_q.push_back(32'h0BADF00D);
        drive(1'b1, 1'b0, 2'd1, 32'h206, 32'h11223344);
        wait_done("lh", 3);
        stall_current_stage = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("done_hold", 96'({bus.ram_req, stall_request}), 96'(0));
        end
        nxt();
        stall_current_stage = 1'b0;
        idle();
        nxt();

        // Misaligned accesses
        drive(1'b1, 1'b0, 2'd1, 32'h101, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lh_mis", 96'({adel_out, ades_out, bus.ram_req, stall_request}),
                  96'(4'b1000));
            nxt();
        end
        drive(1'b0, 1'b1, 2'd2, 32'h102, 32'h0);
        @(negedge clk);
        check("sw_mis", 96'({adel_out, ades_out, bus.ram_req, stall_request}), 96'(4'b0100));
        nxt(); idle(); nxt();

        // Flush in IDLE suppresses the access
        drive(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", 96'(stall_request), 96'(0));
        nxt();
        @(negedge clk);
        check("flush_idle_req", 96'(bus.ram_req), 96'(0));
        nxt();
        flush = 1'b0;
        idle();
        nxt();

        // addr_ok withheld; flush during the third REQ cycle
        addr_lat = 100;
        exp_rd_q.push_back(32'h0BADF00D);
        drive(1'b0, 1'b1, 2'd2, 32'h300, 32'h55667788);
        for (int i = 1; i <= 3; i++) begin
            nxt();
            if (i == 3) flush = 1'b1;
            @(negedge clk);
            check("req_stable", 96'({bus.ram_req, bus.ram_wr, bus.ram_sel, bus.ram_addr}),
                  96'({1'b1, 1'b1, 4'b1111, 32'h300}));
            check("req_stable_wdata", 96'(bus.ram_wdata), 96'(32'h55667788));
        end
        nxt();
        flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_req_drop", 96'({bus.ram_req, stall_request}), 96'(0));
        nxt();
        @(negedge clk);
        check("flush_req_idle", 96'(bus.ram_req), 96'(0));
        nxt();

        // Flush in WAIT, data_ok two cycles later is drained
        addr_lat = 1; data_lat = 3; resp_data = 32'h12345678;
        exp_req_q.push_back({1'b0, 4'b1111, 32'h400, 32'h0});
        exp_rd_q.push_back(32'h0BADF00D);
        drive(1'b1, 1'b0, 2'd2, 32'h400, 32'h0);
        nxt(); nxt(); nxt();
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        idle();
        wait_done("drain", 2);
        nxt();

        // Reset in WAIT; late data_ok must be ignored
        addr_lat = 1; data_lat = 3; resp_data = 32'h87654321;
        exp_req_q.push_back({1'b0, 4'b1111, 32'h500, 32'h0});
        exp_rd_q.push_back(32'h0);
        drive(1'b1, 1'b0, 2'd2, 32'h500, 32'h0);
        nxt(); nxt(); nxt();
        rst = 1'b0;
        idle();
        nxt();
        rst = 1'b1;
        @(negedge clk);
        check("wait_rst_bus", 96'({bus.ram_req, bus.ram_wr, bus.ram_sel, bus.ram_addr}), 96'(0));
        check("wait_rst_wdata", 96'(bus.ram_wdata), 96'(0));
        check("wait_rst_rdata", 96'(ram_read_data_out), 96'(0));
        check("wait_rst_stall", 96'(stall_request), 96'(0));
        nxt(); nxt();
        @(negedge clk);
        check("late_data_ignored", 96'({bus.ram_req, ram_read_data_out}), 96'(0));
        nxt();

        // New lw after reset
        addr_lat = 1; data_lat = 1; resp_data = 32'h0F0F0F0F;
        exp_req_q.push_back({1'b0, 4'b1111, 32'h104, 32'h0});
        exp_rd_q.push_back(32'h0F0F0F0F);
        drive(1'b1, 1'b0, 2'd2, 32'h104, 32'h0);
        wait_done("lw_after_rst", 4);
        nxt(); idle();
        repeat (3) nxt();

        check("req_queue_empty", 96'(exp_req_q.size()), 96'(0));
        check("rd_queue_empty", 96'(exp_rd_q.size()), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
